// File: rtl/cpu_run_ctrl_pkg.sv
// Shared constants and state encoding for the CPU run/step controller.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STEP    = 2'd2
  } state_t;

  // Default debounce hold time: 20 ms at 50 MHz.
  localparam logic [19:0] DEBOUNCE_CYCLES_DEF = 20'd1000000;

  // Prescaler divide ratio that produces the CPU step tick.
  localparam logic [23:0] PRESCALE_DEF = 24'd12500000;

endpackage

// File: rtl/cpu_run_ctrl_button_debouncer.sv
// Button conditioner: 2-flop synchroniser, debounce counter, press pulse.
// Ports: clk, reset (async, active-low), btn (raw), press (1-clk pulse).
module button_debouncer
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned       DB_W            = 20,
  parameter logic [DB_W-1:0]   DEBOUNCE_CYCLES = DB_W'(DEBOUNCE_CYCLES_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DEBOUNCE_CYCLES - DB_W'(1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Registered press coincides with the debounced level rising.
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: turns prescaler ticks and run/step buttons into the
// CPU clock-enable pulse and counts issued pulses.
// Ports: clk, reset (async, active-low), tick, btn_run, btn_step, halt_req
//        -> cpu_ce, running, step_cnt[15:0].
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned     DB_W            = 20,
  parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = DB_W'(DEBOUNCE_CYCLES_DEF)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic        running,
  output logic [15:0] step_cnt
);

  state_t state;
  state_t state_n;
  logic   ce_n;
  logic   run_press;
  logic   step_press;

  button_debouncer #(
    .DB_W            (DB_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_run),
    .press (run_press)
  );

  button_debouncer #(
    .DB_W            (DB_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_step),
    .press (step_press)
  );

  always_comb begin
    state_n = state;
    ce_n    = 1'b0;
    unique case (state)
      ST_HALTED: begin
        if (!halt_req) begin
          if (run_press)       state_n = ST_RUNNING;
          else if (step_press) state_n = ST_STEP;
        end
      end
      ST_RUNNING: begin
        if (halt_req || run_press) state_n = ST_HALTED;
        else                       ce_n    = tick;
      end
      ST_STEP: begin
        if (halt_req) begin
          state_n = ST_HALTED;
        end else if (tick) begin
          state_n = ST_HALTED;
          ce_n    = 1'b1;
        end
      end
      default: state_n = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_HALTED;
      cpu_ce   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state  <= state_n;
      cpu_ce <= ce_n;
      if (cpu_ce) step_cnt <= step_cnt + 16'd1;
    end
  end

  assign running = (state == ST_RUNNING);

endmodule
